riscv_regfile_sb: RTL and testbench

- Parametrised successor of the core register file: PC register, NUM_READ combinational read ports, one write port, optional same-cycle write-to-read bypass.
- Adds a per-register pending-write scoreboard for the pipelined core.
- Adds a post-reset clear sequencer, so the array needs no reset logic and still starts at zero in silicon, not just in simulation.
- Sits between decode/issue (reads, scoreboard set) and writeback (write, scoreboard clear).

---
 rtl/riscv_regfile_sb_pkg.sv | 14 +
 rtl/regfile_scoreboard.sv | 51 +++++
 rtl/riscv_regfile_sb.sv | 124 ++++++++++++
 tb/tb_riscv_regfile_sb.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_regfile_sb_pkg.sv
// Shared core defaults for the scoreboarded register file: widths, reset PC
// and the clear-sequencer state encoding.
package riscv_regfile_sb_pkg;

  localparam int unsigned XLEN_DEF      = 32;
  localparam int unsigned REG_COUNT_DEF = 32;
  localparam logic [63:0] RESET_PC_DEF  = 64'h0;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } rf_state_e;

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: one busy flop per architectural register except x0,
// with issue-over-writeback priority and a per-read-port busy lookup.
module regfile_scoreboard #(
  parameter int unsigned REG_COUNT = 32,
  parameter int unsigned NUM_READ  = 2,
  localparam int unsigned IW       = $clog2(REG_COUNT)
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   set_valid,
  input  logic [IW-1:0]          set_idx,
  input  logic                   clr_valid,
  input  logic [IW-1:0]          clr_idx,
  input  logic [NUM_READ*IW-1:0] rs_index,
  input  logic [NUM_READ-1:0]    hit_mask,
  output logic [NUM_READ-1:0]    rs_busy
);

  logic [REG_COUNT-1:1] busy;
  logic [REG_COUNT-1:1] busy_next;
  logic [REG_COUNT-1:0] busy_full;

  // A new producer supersedes the one completing on the same edge.
  always_comb begin
    busy_next = busy;
    for (int i = 1; i < REG_COUNT; i++) begin
      if (set_valid && (set_idx == IW'(i))) begin
        busy_next[i] = 1'b1;
      end else if (clr_valid && (clr_idx == IW'(i))) begin
        busy_next[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      busy <= '0;
    end else begin
      busy <= busy_next;
    end
  end

  assign busy_full = {busy, 1'b0};

  for (genvar k = 0; k < NUM_READ; k++) begin : g_lookup
    logic [IW-1:0] idx;
    assign idx        = rs_index[k*IW +: IW];
    assign rs_busy[k] = (idx != '0) && busy_full[idx] && !hit_mask[k];
  end

endmodule

// File: rtl/riscv_regfile_sb.sv
// Register file with PC, NUM_READ combinational read ports, one write port,
// optional write-to-read bypass, pending-write scoreboard and post-reset clear.
module riscv_regfile_sb
  import riscv_regfile_sb_pkg::*;
#(
  parameter int unsigned      XLEN      = XLEN_DEF,
  parameter int unsigned      REG_COUNT = REG_COUNT_DEF,
  parameter int unsigned      NUM_READ  = 2,
  parameter int unsigned      BYPASS    = 1,
  parameter logic [XLEN-1:0]  RESET_PC  = XLEN'(RESET_PC_DEF),
  localparam int unsigned     IW        = $clog2(REG_COUNT)
) (
  input  logic                     clock,
  input  logic                     reset,
  output logic                     ready,
  input  logic                     enable_write_pc,
  input  logic [XLEN-1:0]          pc_next,
  output logic [XLEN-1:0]          pc_val,
  input  logic [NUM_READ*IW-1:0]   rs_index,
  output logic [NUM_READ*XLEN-1:0] rs,
  output logic [NUM_READ-1:0]      rs_busy,
  input  logic                     issue_valid,
  input  logic [IW-1:0]            issue_rd,
  input  logic                     enable_write_rd,
  input  logic [IW-1:0]            rd_index,
  input  logic [XLEN-1:0]          rd
);

  localparam logic [IW-1:0] CLR_LAST = IW'(REG_COUNT - 1);

  rf_state_e        state;
  rf_state_e        state_next;
  logic [IW-1:0]    clr_idx;
  logic [IW-1:0]    clr_idx_next;
  logic [XLEN-1:0]  pc;
  logic [XLEN-1:0]  regs [REG_COUNT];

  logic             wr_run;
  logic             wr_en;
  logic [IW-1:0]    wr_addr;
  logic [XLEN-1:0]  wr_data;
  logic             set_valid;
  logic [NUM_READ-1:0] byp_hit;

  assign ready     = (state == ST_RUN);
  assign wr_run    = ready && enable_write_rd && (rd_index != '0);
  assign set_valid = ready && issue_valid;

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= ST_CLEAR;
      clr_idx <= IW'(1);
    end else begin
      state   <= state_next;
      clr_idx <= clr_idx_next;
    end
  end

  // The last clear write and the switch to RUN share one edge.
  always_comb begin
    state_next   = state;
    clr_idx_next = clr_idx;
    if (state == ST_CLEAR) begin
      clr_idx_next = clr_idx + 1'b1;
      if (clr_idx == CLR_LAST) begin
        state_next = ST_RUN;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pc <= RESET_PC;
    end else if (ready && enable_write_pc) begin
      pc <= pc_next;
    end
  end

  assign pc_val = pc;

  // The clear sequencer borrows the single write port until RUN.
  always_comb begin
    wr_en   = 1'b0;
    wr_addr = rd_index;
    wr_data = rd;
    if (state == ST_CLEAR) begin
      wr_en   = 1'b1;
      wr_addr = clr_idx;
      wr_data = '0;
    end else if (wr_run) begin
      wr_en = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (wr_en) begin
      regs[wr_addr] <= wr_data;
    end
  end

  for (genvar k = 0; k < NUM_READ; k++) begin : g_rd
    logic [IW-1:0] idx;
    assign idx        = rs_index[k*IW +: IW];
    assign byp_hit[k] = (BYPASS != 0) && wr_run && (rd_index == idx);
    assign rs[k*XLEN +: XLEN] = (idx == '0) ? '0 :
                                byp_hit[k]  ? rd : regs[idx];
  end

  regfile_scoreboard #(
    .REG_COUNT (REG_COUNT),
    .NUM_READ  (NUM_READ)
  ) u_scoreboard (
    .clock     (clock),
    .reset     (reset),
    .set_valid (set_valid),
    .set_idx   (issue_rd),
    .clr_valid (wr_run),
    .clr_idx   (rd_index),
    .rs_index  (rs_index),
    .hit_mask  (byp_hit),
    .rs_busy   (rs_busy)
  );

endmodule

// File: tb/tb_riscv_regfile_sb.sv
// Bench for riscv_regfile_sb: a 32-entry, 4-port bypassing instance and a
// 16-entry, 2-port non-bypassing instance, checked against a small model.
module tb_riscv_regfile_sb;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  int checks   = 0;
  int failures = 0;
  logic [31:0] exp_q [$];
  logic [31:0] got;
  logic [31:0] exp;
  logic [31:0] ma [32];
  logic [31:0] mb [16];

  // Instance A: 32 regs, 4 read ports, bypass on, RESET_PC = 0
  logic        reset_a, ready_a, epc_a, iv_a, ewr_a;
  logic [31:0] pcn_a, pc_a, rd_a;
  logic [19:0] rsi_a;
  logic [127:0] rs_a;
  logic [3:0]  busy_a;
  logic [4:0]  ird_a, rdi_a;

  // Instance B: 16 regs, 2 read ports, bypass off, RESET_PC = 0x80
  logic        reset_b, ready_b, epc_b, iv_b, ewr_b;
  logic [31:0] pcn_b, pc_b, rd_b;
  logic [7:0]  rsi_b;
  logic [63:0] rs_b;
  logic [1:0]  busy_b;
  logic [3:0]  ird_b, rdi_b;

  riscv_regfile_sb #(
    .XLEN(32), .REG_COUNT(32), .NUM_READ(4), .BYPASS(1), .RESET_PC(32'h0)
  ) u_a (
    .clock(clock), .reset(reset_a), .ready(ready_a),
    .enable_write_pc(epc_a), .pc_next(pcn_a), .pc_val(pc_a),
    .rs_index(rsi_a), .rs(rs_a), .rs_busy(busy_a),
    .issue_valid(iv_a), .issue_rd(ird_a),
    .enable_write_rd(ewr_a), .rd_index(rdi_a), .rd(rd_a)
  );

  riscv_regfile_sb #(
    .XLEN(32), .REG_COUNT(16), .NUM_READ(2), .BYPASS(0), .RESET_PC(32'h80)
  ) u_b (
    .clock(clock), .reset(reset_b), .ready(ready_b),
    .enable_write_pc(epc_b), .pc_next(pcn_b), .pc_val(pc_b),
    .rs_index(rsi_b), .rs(rs_b), .rs_busy(busy_b),
    .issue_valid(iv_b), .issue_rd(ird_b),
    .enable_write_rd(ewr_b), .rd_index(rdi_b), .rd(rd_b)
  );

  task automatic tick;
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic idle_a;
    epc_a = 1'b0; iv_a = 1'b0; ewr_a = 1'b0;
  endtask

  task automatic test_reset;
    int n;
    reset_a = 1'b1; idle_a();
    tick();
    reset_a = 1'b0;
    #1;
    exp_q.push_back(32'h0); exp_q.push_back(32'h0); exp_q.push_back(32'h0);
    got = {31'b0, ready_a}; exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin failures++; $display("FAIL reset_ready got=%0h exp=%0h", got, exp); end
    got = pc_a; exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin failures++; $display("FAIL reset_pc got=%0h exp=%0h", got, exp); end
    got = {28'b0, busy_a}; exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin failures++; $display("FAIL reset_busy got=%0h exp=%0h", got, exp); end
    n = 0;
    while (ready_a !== 1'b1 && n < 40) begin
      if (n >= 4) begin
        ewr_a = 1'b1; rdi_a = 5'd2; rd_a = 32'hAAAA_5555;
        epc_a = 1'b1; pcn_a = 32'h44; iv_a = 1'b1; ird_a = 5'd2;
      end
      tick(); n++;
    end
    idle_a();
    exp_q.push_back(32'd31);
    got = n; exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin failures++; $display("FAIL clear_cycles got=%0d exp=%0d", got, exp); end
    rsi_a = {5'd0, 5'd0, 5'd5, 5'd2};
    #1;
    exp_q.push_back(ma[2]); exp_q.push_back(ma[5]); exp_q.push_back(32'h0); exp_q.push_back(32'h0);
    got = rs_a[31:0]; exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin failures++; $display("FAIL clear_write_blocked got=%0h exp=%0h", got, exp); end
    got = rs_a[63:32]; exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin failures++; $display("FAIL read_x5_zero got=%0h exp=%0h", got, exp); end
    got = pc_a; exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin failures++; $display("FAIL clear_pc_blocked got=%0h exp=%0h", got, exp); end
    got = {28'b0, busy_a}; exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin failures++; $display("FAIL clear_issue_blocked got=%0h exp=%0h", got, exp); end
  endtask

  task automatic test_reset_small;
    int n;
    reset_b = 1'b1;
    tick();
    reset_b = 1'b0;
    #1;
    exp_q.push_back(32'h80);
    got = pc_b; exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin failures++; $display("FAIL small_reset_pc got=%0h exp=%0h", got, exp); end
    n = 0;
    while (ready_b !== 1'b1 && n < 40) begin tick(); n++; end
    exp_q.push_back(32'd15);
    got = n; exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin failures++; $display("FAIL small_clear_cycles got=%0d exp=%0d", got, exp); end
  endtask

  task automatic test_bypass_on;
    rsi_a = {5'd0, 5'd0, 5'd0, 5'd3};
    ewr_a = 1'b1; rdi_a = 5'd3; rd_a = 32'hDEAD_BEEF;
    ma[3] = 32'hDEAD_BEEF;
    exp_q.push_back(ma[3]);
    #1;
    got = rs_a[31:0]; exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin failures++; $display("FAIL bypass_same_cycle got=%0h exp=%0h", got, exp); end
    tick(); idle_a();
    exp_q.push_back(ma[3]);
    #1;
    got = rs_a[31:0]; exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin failures++; $display("FAIL bypass_next_cycle got=%0h exp=%0h", got, exp); end
  endtask

  task automatic test_bypass_off;
    rsi_b = {4'd0, 4'd3};
    ewr_b = 1'b1; rdi_b = 4'd3; rd_b = 32'hDEAD_BEEF;
    exp_q.push_back(mb[3]);
    mb[3] = 32'hDEAD_BEEF;
    #1;
    got = rs_b[31:0]; exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin failures++; $display("FAIL nobypass_old got=%0h exp=%0h", got, exp); end
    tick(); ewr_b = 1'b0;
    exp_q.push_back(mb[3]);
    #1;
    got = rs_b[31:0]; exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin failures++; $display("FAIL nobypass_new got=%0h exp=%0h", got, exp); end
  endtask

  task automatic test_x0;
    rsi_a = '0;
    ewr_a = 1'b1; rdi_a = 5'd0; rd_a = 32'h1234;
    iv_a = 1'b1; ird_a = 5'd0;
    #1;
    for (int k = 0; k < 4; k++) exp_q.push_back(32'h0);
    for (int k = 0; k < 4; k++) begin
      got = rs_a[k*32 +: 32]; exp = exp_q.pop_front(); checks++;
      if (got !== exp) begin failures++; $display("FAIL x0_same_cycle port=%0d got=%0h exp=%0h", k, got, exp); end
    end
    tick(); idle_a();
    #1;
    exp_q.push_back(32'h0); exp_q.push_back(32'h0);
    got = rs_a[31:0]; exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin failures++; $display("FAIL x0_after got=%0h exp=%0h", got, exp); end
    got = {28'b0, busy_a}; exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin failures++; $display("FAIL x0_busy got=%0h exp=%0h", got, exp); end
  endtask

  task automatic test_scoreboard;
    rsi_a = {4{5'd7}};
    iv_a = 1'b1; ird_a = 5'd7;
    #1;
    exp_q.push_back(32'h0);
    got = {31'b0, busy_a[0]}; exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin failures++; $display("FAIL busy_not_comb got=%0h exp=%0h", got, exp); end
    tick(); idle_a();
    #1;
    exp_q.push_back(32'h1);
    got = {31'b0, busy_a[0]}; exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin failures++; $display("FAIL busy_set got=%0h exp=%0h", got, exp); end
    ewr_a = 1'b1; rdi_a = 5'd7; rd_a = 32'h77; ma[7] = 32'h77;
    #1;
    exp_q.push_back(32'h0); exp_q.push_back(ma[7]);
    got = {31'b0, busy_a[0]}; exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin failures++; $display("FAIL busy_bypass_mask got=%0h exp=%0h", got, exp); end
    got = rs_a[31:0]; exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin failures++; $display("FAIL wb_bypass_data got=%0h exp=%0h", got, exp); end
    tick(); idle_a();
    #1;
    exp_q.push_back(32'h0);
    got = {28'b0, busy_a}; exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin failures++; $display("FAIL busy_clear got=%0h exp=%0h", got, exp); end
    iv_a = 1'b1; ird_a = 5'd7;
    tick();
    ewr_a = 1'b1; rdi_a = 5'd7; rd_a = 32'h78; ma[7] = 32'h78;
    tick(); idle_a();
    #1;
    exp_q.push_back(32'hF); exp_q.push_back(ma[7]);
    got = {28'b0, busy_a}; exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin failures++; $display("FAIL set_wins_busy got=%0h exp=%0h", got, exp); end
    got = rs_a[31:0]; exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin failures++; $display("FAIL set_wins_data got=%0h exp=%0h", got, exp); end
  endtask

  task automatic test_four_ports;
    ewr_a = 1'b1; rdi_a = 5'd9; rd_a = 32'h55; ma[9] = 32'h55;
    iv_a = 1'b1; ird_a = 5'd9;
    tick(); idle_a();
    rsi_a = {4{5'd9}};
    #1;
    for (int k = 0; k < 4; k++) exp_q.push_back(ma[9]);
    exp_q.push_back(32'hF);
    for (int k = 0; k < 4; k++) begin
      got = rs_a[k*32 +: 32]; exp = exp_q.pop_front(); checks++;
      if (got !== exp) begin failures++; $display("FAIL four_port_data port=%0d got=%0h exp=%0h", k, got, exp); end
    end
    got = {28'b0, busy_a}; exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin failures++; $display("FAIL four_port_busy got=%0h exp=%0h", got, exp); end
  endtask

  task automatic test_back_to_back;
    rsi_a = {5'd10, 5'd9, 5'd10, 5'd9};
    iv_a = 1'b1; ird_a = 5'd10;
    ewr_a = 1'b1; rdi_a = 5'd9; rd_a = 32'h66; ma[9] = 32'h66;
    tick(); idle_a();
    #1;
    exp_q.push_back(32'hA); exp_q.push_back(ma[9]); exp_q.push_back(ma[10]);
    got = {28'b0, busy_a}; exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin failures++; $display("FAIL indep_busy got=%0h exp=%0h", got, exp); end
    got = rs_a[31:0]; exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin failures++; $display("FAIL indep_data9 got=%0h exp=%0h", got, exp); end
    got = rs_a[63:32]; exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin failures++; $display("FAIL indep_data10 got=%0h exp=%0h", got, exp); end
  endtask

  task automatic test_reset_midrun;
    int n;
    epc_a = 1'b1; pcn_a = 32'h100;
    tick(); idle_a();
    rsi_a = {4{5'd10}};
    #1;
    exp_q.push_back(32'h100); exp_q.push_back(32'hF);
    got = pc_a; exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin failures++; $display("FAIL pc_load got=%0h exp=%0h", got, exp); end
    got = {28'b0, busy_a}; exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin failures++; $display("FAIL pre_reset_busy got=%0h exp=%0h", got, exp); end
    reset_a = 1'b1;
    tick();
    #1;
    exp_q.push_back(32'h0); exp_q.push_back(32'h0); exp_q.push_back(32'h0);
    got = pc_a; exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin failures++; $display("FAIL midrun_pc got=%0h exp=%0h", got, exp); end
    got = {31'b0, ready_a}; exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin failures++; $display("FAIL midrun_ready got=%0h exp=%0h", got, exp); end
    got = {28'b0, busy_a}; exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin failures++; $display("FAIL midrun_busy got=%0h exp=%0h", got, exp); end
    reset_a = 1'b0;
    n = 0;
    while (ready_a !== 1'b1 && n < 40) begin tick(); n++; end
    exp_q.push_back(32'd31);
    got = n; exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin failures++; $display("FAIL restart_cycles got=%0d exp=%0d", got, exp); end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) ma[i] = 32'h0;
    for (int i = 0; i < 16; i++) mb[i] = 32'h0;
    reset_a = 1'b1; reset_b = 1'b1;
    epc_a = 1'b0; pcn_a = '0; rsi_a = '0; iv_a = 1'b0; ird_a = '0; ewr_a = 1'b0; rdi_a = '0; rd_a = '0;
    epc_b = 1'b0; pcn_b = '0; rsi_b = '0; iv_b = 1'b0; ird_b = '0; ewr_b = 1'b0; rdi_b = '0; rd_b = '0;
    @(negedge clock);
    test_reset();
    test_reset_small();
    test_bypass_on();
    test_bypass_off();
    test_x0();
    test_scoreboard();
    test_four_ports();
    test_back_to_back();
    test_reset_midrun();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
